// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: the retired-instruction record
// and the helpers used to normalise it before storage.
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } commit_rec_t;

  localparam logic [4:0] TRACE_X0 = 5'd0;

  // x0 is hardwired to zero, so a write to it never changes architectural state.
  function automatic logic norm_wen(input logic wen, input logic [4:0] waddr);
    return wen && (waddr != TRACE_X0);
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit (writeback -> buffer) and trace (buffer -> checker) val/rdy channels.
// The master side is the processor/harness; the slave side is the buffer.
interface commit_trace_buffer_if #(
    parameter int unsigned p_seq_bits = 16
);

    logic                  commit_val;
    logic                  commit_rdy;
    logic [31:0]           commit_pc;
    logic [4:0]            commit_waddr;
    logic [31:0]           commit_wdata;
    logic                  commit_wen;

    logic                  trace_val;
    logic                  trace_rdy;
    logic [31:0]           trace_pc;
    logic [4:0]            trace_waddr;
    logic [31:0]           trace_wdata;
    logic                  trace_wen;
    logic [p_seq_bits-1:0] trace_seq;

    modport master (
        output commit_val,
        output commit_pc,
        output commit_waddr,
        output commit_wdata,
        output commit_wen,
        input  commit_rdy,
        input  trace_val,
        input  trace_pc,
        input  trace_waddr,
        input  trace_wdata,
        input  trace_wen,
        input  trace_seq,
        output trace_rdy
    );

    modport slave (
        input  commit_val,
        input  commit_pc,
        input  commit_waddr,
        input  commit_wdata,
        input  commit_wen,
        output commit_rdy,
        output trace_val,
        output trace_pc,
        output trace_waddr,
        output trace_wdata,
        output trace_wen,
        output trace_seq,
        input  trace_rdy
    );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Storage and pointer FIFO for commit records plus their sequence numbers.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned p_depth    = 4,
    parameter int unsigned p_seq_bits = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  commit_rec_t               push_rec,
    input  logic [p_seq_bits-1:0]     push_seq,
    input  logic                      pop,
    output commit_rec_t               head_rec,
    output logic [p_seq_bits-1:0]     head_seq,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(p_depth):0]  count
);

    localparam int unsigned AddrW = $clog2(p_depth);
    localparam int unsigned PtrW  = AddrW + 1;

    commit_rec_t           mem_rec [p_depth];
    logic [p_seq_bits-1:0] mem_seq [p_depth];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0] head_idx;
    logic             do_push, do_pop;

    always_comb begin
        full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        count = wr_ptr_q - rd_ptr_q;
    end

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rec[wr_ptr_q[AddrW-1:0]] <= push_rec;
            mem_seq[wr_ptr_q[AddrW-1:0]] <= push_seq;
        end
    end

    // When empty, point at the slot just popped so the outputs hold its values.
    always_comb begin
        head_idx = rd_ptr_q[AddrW-1:0];
        if (empty) begin
            head_idx = rd_ptr_q[AddrW-1:0] - AddrW'(1);
        end
        head_rec = mem_rec[head_idx];
        head_seq = mem_seq[head_idx];
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers retired-instruction records from writeback and replays them in
// program order to the trace checker, tagging each with a sequence number.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned p_depth    = 4,
    parameter int unsigned p_seq_bits = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    commit_trace_buffer_if.slave     bus,
    output logic [$clog2(p_depth):0] count,
    output logic                     overflow
);

    logic                  full, empty;
    logic                  push, pop;
    commit_rec_t           push_rec, head_rec;
    logic [p_seq_bits-1:0] head_seq;
    logic [p_seq_bits-1:0] seq_q, seq_d;
    logic                  overflow_q, overflow_d;

    // No full-bypass: a pop in the same cycle does not free a slot for this push.
    assign bus.commit_rdy = !full;
    assign bus.trace_val  = !empty;
    assign push           = bus.commit_val && !full;
    assign pop            = bus.trace_val && bus.trace_rdy;

    always_comb begin
        push_rec.pc    = bus.commit_pc;
        push_rec.waddr = bus.commit_waddr;
        push_rec.wdata = bus.commit_wdata;
        push_rec.wen   = norm_wen(bus.commit_wen, bus.commit_waddr);
    end

    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        if (push) begin
            seq_d = seq_q + p_seq_bits'(1);
        end
        if (bus.commit_val && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .p_depth    (p_depth),
        .p_seq_bits (p_seq_bits)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_rec (push_rec),
        .push_seq (seq_q),
        .pop      (pop),
        .head_rec (head_rec),
        .head_seq (head_seq),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_comb begin
        bus.trace_pc    = head_rec.pc;
        bus.trace_waddr = head_rec.waddr;
        bus.trace_wdata = head_rec.wdata;
        bus.trace_wen   = head_rec.wen;
        bus.trace_seq   = head_seq;
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a scoreboard queue filled by the
// stimulus side and drained by a monitor on every trace handshake.
module tb_commit_trace_buffer;

    localparam int unsigned Depth   = 4;
    localparam int unsigned SeqBits = 16;

    typedef struct packed {
        logic [31:0]        pc;
        logic [4:0]         waddr;
        logic [31:0]        wdata;
        logic               wen;
        logic [SeqBits-1:0] seq;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       overflow;

    int unsigned        total;
    int unsigned        bad;
    exp_t               sb[$];
    logic [SeqBits-1:0] exp_seq;

    commit_trace_buffer_if #(.p_seq_bits(SeqBits)) bus ();

    commit_trace_buffer #(
        .p_depth    (Depth),
        .p_seq_bits (SeqBits)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every trace handshake must match the oldest expected record.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (rst && bus.trace_val && bus.trace_rdy) begin
                a.pc    = bus.trace_pc;
                a.waddr = bus.trace_waddr;
                a.wdata = bus.trace_wdata;
                a.wen   = bus.trace_wen;
                a.seq   = bus.trace_seq;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL record_unexpected: got %0h expected none", a);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL record: got pc=%0h waddr=%0d wdata=%0h wen=%0b seq=%0d expected pc=%0h waddr=%0d wdata=%0h wen=%0b seq=%0d",
                                 a.pc, a.waddr, a.wdata, a.wen, a.seq,
                                 e.pc, e.waddr, e.wdata, e.wen, e.seq);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        exp_seq = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] waddr,
                          input logic [31:0] wdata, input logic wen, input bit accept);
        exp_t e;
        bus.commit_val   = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_waddr = waddr;
        bus.commit_wdata = wdata;
        bus.commit_wen   = wen;
        if (accept) begin
            e.pc    = pc;
            e.waddr = waddr;
            e.wdata = wdata;
            e.wen   = wen && (waddr != 5'd0);
            e.seq   = exp_seq;
            sb.push_back(e);
            exp_seq++;
        end
        @(posedge clk);
        #1;
        bus.commit_val = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_seq = '0;
        rst = 1'b1;
        bus.commit_val   = 1'b0;
        bus.commit_pc    = '0;
        bus.commit_waddr = '0;
        bus.commit_wdata = '0;
        bus.commit_wen   = 1'b0;
        bus.trace_rdy    = 1'b0;
        #2;

        // Reset then idle
        do_reset();
        check("reset_trace_val", bus.trace_val, 0);
        check("reset_commit_rdy", bus.commit_rdy, 1);
        check("reset_count", count, 0);
        check("reset_overflow", overflow, 0);

        // Single commit, visible one cycle later
        commit(32'h200, 5'd5, 32'h1234, 1'b1, 1'b1);
        check("single_trace_val", bus.trace_val, 1);
        check("single_count", count, 1);
        check("single_seq", bus.trace_seq, 0);
        check("single_pc", bus.trace_pc, 32'h200);
        bus.trace_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.trace_rdy = 1'b0;
        check("single_count_after_pop", count, 0);
        check("single_val_after_pop", bus.trace_val, 0);

        // Fill to depth, then overflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            commit(32'h200 + 32'(4 * i), 5'(i + 1), 32'h11 * 32'(i), 1'b1, 1'b1);
        end
        check("fill_commit_rdy", bus.commit_rdy, 0);
        check("fill_count", count, 4);
        check("fill_overflow_before", overflow, 0);
        commit(32'h210, 5'd9, 32'h99, 1'b1, 1'b0);
        check("fill_overflow_set", overflow, 1);
        check("fill_count_after_drop", count, 4);
        bus.trace_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.trace_rdy = 1'b0;
        check("drain_count", count, 0);
        check("drain_overflow_sticky", overflow, 1);
        check("drain_commit_rdy", bus.commit_rdy, 1);

        // Writes to x0 are normalised to wen=0; plain wen=0 kept
        do_reset();
        commit(32'h300, 5'd0, 32'hdead, 1'b1, 1'b1);
        check("x0_trace_wen", bus.trace_wen, 0);
        check("x0_trace_waddr", bus.trace_waddr, 0);
        check("x0_trace_wdata", bus.trace_wdata, 32'hdead);
        commit(32'h304, 5'd7, 32'hbeef, 1'b0, 1'b1);
        bus.trace_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.trace_rdy = 1'b0;

        // Streaming: back-to-back commits with the checker always ready
        do_reset();
        bus.trace_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            bus.commit_val   = 1'b1;
            bus.commit_pc    = 32'h1000 + 32'(4 * i);
            bus.commit_waddr = 5'(i + 1);
            bus.commit_wdata = 32'h5000 + 32'(i);
            bus.commit_wen   = i[0];
            e.pc    = bus.commit_pc;
            e.waddr = bus.commit_waddr;
            e.wdata = bus.commit_wdata;
            e.wen   = i[0];
            e.seq   = exp_seq;
            sb.push_back(e);
            exp_seq++;
            @(posedge clk);
            #1;
            check("stream_count_le1", 64'(count <= 3'd1), 1);
            check("stream_trace_val", bus.trace_val, 1);
        end
        bus.commit_val = 1'b0;
        @(posedge clk);
        #1;
        check("stream_count_end", count, 0);
        bus.trace_rdy = 1'b0;

        // Asynchronous reset with records buffered
        do_reset();
        for (int i = 0; i < 3; i++) begin
            commit(32'h400 + 32'(4 * i), 5'd3, 32'(i), 1'b1, 1'b1);
        end
        check("midrst_count_before", count, 3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        exp_seq = '0;
        #1;
        check("midrst_trace_val", bus.trace_val, 0);
        check("midrst_count", count, 0);
        check("midrst_commit_rdy", bus.commit_rdy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        commit(32'h500, 5'd4, 32'h77, 1'b1, 1'b1);
        check("midrst_seq_restart", bus.trace_seq, 0);
        bus.trace_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.trace_rdy = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("scoreboard_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
